// File: rtl/valid_ready_deserializer.sv
// valid_ready_deserializer
// Packs up to BEATS narrow WIDTH-bit valid-ready beats into one wide word
// presented on a registered valid-ready output. input_last closes a partial
// word early; unwritten upper slots of a partial word read as zero.
module valid_ready_deserializer #(
  parameter  int WIDTH       = 8,
  parameter  int BEATS       = 4,
  localparam int COUNT_WIDTH = $clog2(BEATS + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         input_data,
  input  logic                     input_last,
  input  logic                     input_valid,
  output logic                     input_ready,
  output logic [WIDTH*BEATS-1:0]   output_data,
  output logic [COUNT_WIDTH-1:0]   output_beats,
  output logic                     output_valid,
  input  logic                     output_ready
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(BEATS - 1);

  // Collection state
  logic [WIDTH*BEATS-1:0] r_buffer;
  logic [COUNT_WIDTH-1:0] r_count;

  // Output register
  logic [WIDTH*BEATS-1:0] r_out_data;
  logic [COUNT_WIDTH-1:0] r_out_beats;
  logic                   r_out_valid;

  // Handshake and merge wires
  logic                   w_accept;
  logic                   w_complete;
  logic                   w_drain;
  logic [WIDTH*BEATS-1:0] w_merged;

  // A new beat fits whenever the output slot is empty or being emptied now;
  // this never looks at input_valid, so upstream sees no combinational loop.
  assign input_ready = ~r_out_valid | output_ready;

  assign w_accept   = input_valid & input_ready;
  assign w_complete = w_accept & ((r_count == LAST_IDX) | input_last);
  assign w_drain    = r_out_valid & output_ready;

  // Build the word as it would look with the incoming beat placed in its slot:
  // earlier slots come from the buffer, later slots are forced to zero.
  always_comb begin
    // NOTE: default first so every path assigns w_merged and no latch is inferred.
    w_merged = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (COUNT_WIDTH'(k) == r_count) begin
        w_merged[k*WIDTH +: WIDTH] = input_data;
      end else if (COUNT_WIDTH'(k) < r_count) begin
        w_merged[k*WIDTH +: WIDTH] = r_buffer[k*WIDTH +: WIDTH];
      end
    end
  end

  // Collection buffer and beat counter: fill on accept, clear on completion.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the buffer is plain flops, reset to zero so a reset mid-word leaves
    // no stale beats behind to leak into the next word.
    if (reset) begin
      r_buffer <= '0;
      r_count  <= '0;
    end else if (w_complete) begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      r_buffer <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_buffer <= w_merged;
      r_count  <= r_count + COUNT_WIDTH'(1);
    end
  end

  // Output register: reload on a completing beat (even while draining, so
  // back-to-back words flow without a bubble), otherwise clear valid on drain.
  // Under backpressure nothing here changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_valid <= 1'b0;
    end else if (w_complete) begin
      r_out_data  <= w_merged;
      r_out_beats <= r_count + COUNT_WIDTH'(1);
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign output_data  = r_out_data;
  assign output_beats = r_out_beats;
  assign output_valid = r_out_valid;

endmodule

// File: tb/tb_valid_ready_deserializer.sv
// tb_valid_ready_deserializer
// Directed tests for the default WIDTH=8, BEATS=4 configuration plus a
// randomised scoreboard run on a BEATS=1 instance.
module tb_valid_ready_deserializer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // BEATS=4 instance
  logic [7:0]  in_data  = '0;
  logic        in_last  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_beats;
  logic        out_valid;
  logic        out_ready = 1'b0;

  // BEATS=1 instance
  logic [7:0]  b1_data  = '0;
  logic        b1_valid = 1'b0;
  logic        b1_in_ready;
  logic [7:0]  b1_out_data;
  logic [0:0]  b1_out_beats;
  logic        b1_out_valid;
  logic        b1_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  valid_ready_deserializer #(.WIDTH(8), .BEATS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_data   (in_data),
    .input_last   (in_last),
    .input_valid  (in_valid),
    .input_ready  (in_ready),
    .output_data  (out_data),
    .output_beats (out_beats),
    .output_valid (out_valid),
    .output_ready (out_ready)
  );

  valid_ready_deserializer #(.WIDTH(8), .BEATS(1)) dut1 (
    .clock        (clock),
    .reset        (reset),
    .input_data   (b1_data),
    .input_last   (1'b0),
    .input_valid  (b1_valid),
    .input_ready  (b1_in_ready),
    .output_data  (b1_out_data),
    .output_beats (b1_out_beats),
    .output_valid (b1_out_valid),
    .output_ready (b1_ready)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one beat, wait (bounded) for input_ready, complete the handshake.
  // Returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      step();
      #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL send_beat_timeout data=%h input_ready=%b required 1", d, in_ready);
      errors++;
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [31:0] exp_data,
                            input logic [2:0] exp_beats);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data || out_beats !== exp_beats) begin
      $display("FAIL %s valid=%b data=%h beats=%0d required valid=1 data=%h beats=%0d",
               name, out_valid, out_data, out_beats, exp_data, exp_beats);
      errors++;
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL %s valid=%b required 0", name, out_valid);
      errors++;
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_beats !== 3'd0 ||
        in_ready !== 1'b1 || b1_out_valid !== 1'b0 || b1_out_data !== 8'h0) begin
      $display("FAIL %s valid=%b data=%h beats=%0d in_ready=%b b1_valid=%b b1_data=%h required 0/0/0/1/0/0",
               name, out_valid, out_data, out_beats, in_ready, b1_out_valid, b1_out_data);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    check_zero("reset_state");
    step();
    step();
    reset = 1'b0;
    step();
    check_zero("after_reset_release");
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    check_idle("full_word_not_early");
    send_beat(8'h44, 1'b0);
    check_word("full_word", 32'h44332211, 3'd4);
    step();
    check_idle("full_word_drained");
  endtask

  task automatic test_last();
    out_ready = 1'b1;
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    check_word("last_partial", 32'h0000BBAA, 3'd2);
    send_beat(8'h01, 1'b0);
    check_idle("last_drain_on_next_beat");
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    check_word("last_restart_slot0", 32'h04030201, 3'd4);
    send_beat(8'h7E, 1'b1);
    check_word("last_on_beat0", 32'h0000007E, 3'd1);
    step();
    check_idle("last_drained");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b0);
    send_beat(8'hA3, 1'b0);
    send_beat(8'hA4, 1'b0);
    check_word("bp_pending", 32'hA4A3A2A1, 3'd4);
    in_data  = 8'h5A;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL bp_input_ready cycle=%0d got=%b required 0", i, in_ready);
        errors++;
      end
      check_word("bp_hold", 32'hA4A3A2A1, 3'd4);
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL bp_release_ready got=%b required 1", in_ready);
      errors++;
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_word("bp_reload_no_bubble", 32'h0000005A, 3'd1);
    step();
    check_idle("bp_drained");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pat [64];
    logic [31:0] exp_w;
    int          widx;
    widx = 0;
    for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
    out_ready = 1'b1;
    for (int c = 0; c < 66; c++) begin
      if (c < 64) begin
        in_valid = 1'b1;
        in_data  = pat[c];
        in_last  = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          $display("FAIL b2b_input_ready cycle=%0d got=%b required 1", c, in_ready);
          errors++;
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid === 1'b1) begin
        checks++;
        if (widx >= 16) begin
          $display("FAIL b2b_extra_word data=%h required no word", out_data);
          errors++;
        end else begin
          exp_w = {pat[4*widx+3], pat[4*widx+2], pat[4*widx+1], pat[4*widx]};
          if (out_data !== exp_w || out_beats !== 3'd4) begin
            $display("FAIL b2b_word idx=%0d data=%h beats=%0d required data=%h beats=4",
                     widx, out_data, out_beats, exp_w);
            errors++;
          end
        end
        widx++;
      end
    end
    checks++;
    if (widx != 16) begin
      $display("FAIL b2b_word_count got=%0d required 16", widx);
      errors++;
    end
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b0;
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0);
    send_beat(8'hC4, 1'b0);
    check_word("rst_pending_word", 32'hC4C3C2C1, 3'd4);
    reset = 1'b1;
    #1;
    check_zero("rst_drops_pending");
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    send_beat(8'hE1, 1'b0);
    send_beat(8'hE2, 1'b0);
    reset = 1'b1;
    #1;
    check_zero("rst_mid_word");
    step();
    reset = 1'b0;
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    check_word("rst_no_residue", 32'h88776655, 3'd4);
    step();
    check_idle("rst_drained");
  endtask

  task automatic test_beats1();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    for (int c = 0; c < 1000; c++) begin
      b1_valid = 1'($urandom_range(0, 1));
      b1_data  = 8'($urandom);
      b1_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (b1_in_ready !== (~b1_out_valid | b1_ready)) begin
        $display("FAIL b1_input_ready cycle=%0d got=%b required %b",
                 c, b1_in_ready, ~b1_out_valid | b1_ready);
        errors++;
      end
      if (b1_valid && b1_in_ready) q.push_back(b1_data);
      if (b1_out_valid && b1_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL b1_duplicate cycle=%0d data=%h required no word", c, b1_out_data);
          errors++;
        end else begin
          exp_d = q.pop_front();
          if (b1_out_data !== exp_d || b1_out_beats !== 1'b1) begin
            $display("FAIL b1_word cycle=%0d data=%h beats=%0d required data=%h beats=1",
                     c, b1_out_data, b1_out_beats, exp_d);
            errors++;
          end
        end
      end
      step();
    end
    b1_valid = 1'b0;
    b1_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (b1_out_valid) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL b1_tail_duplicate data=%h required no word", b1_out_data);
          errors++;
        end else begin
          exp_d = q.pop_front();
          if (b1_out_data !== exp_d) begin
            $display("FAIL b1_tail_word data=%h required %h", b1_out_data, exp_d);
            errors++;
          end
        end
      end
      step();
    end
    checks++;
    if (q.size() != 0 || b1_out_valid !== 1'b0) begin
      $display("FAIL b1_loss remaining=%0d valid=%b required 0/0", q.size(), b1_out_valid);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_beats1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
